mac_rx_arbiter: RTL and testbench
=================================

# mac_rx_arbiter

Frame-level round-robin arbiter that drains four receive MAC ports (each a byte data FIFO plus a 16-bit frame-pointer FIFO) into one shared switch-core ingress FIFO pair. The block sits between the per-port receive MACs and the switch core. It moves one whole frame at a time and tags each forwarded frame with its source port. It drops frames marked bad or carrying an illegal length, and stalls admission until the ingress side has room for the complete frame.

## Interface
- MAX_LEN, 1518: largest legal frame length in bytes; longer frames are dropped.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ptr_fifo_empty  in  4  per-port pointer FIFO empty, bit i = port i
- ptr_fifo_rd  out  4  per-port pointer FIFO read strobe
- ptr_fifo_din  in  64  per-port pointer word, port i at [16i+15:16i]
- data_fifo_rd  out  4  per-port data FIFO read strobe
- data_fifo_din  in  32  per-port data byte, port i at [8i+7:8i]
- out_data  out  8  byte to ingress data FIFO
- out_data_wr  out  1  ingress data FIFO write strobe
- out_ptr  out  16  pointer word to ingress pointer FIFO
- out_ptr_wr  out  1  ingress pointer FIFO write strobe
- out_ptr_full  in  1  ingress pointer FIFO full
- out_data_free  in  12  free byte locations in ingress data FIFO
- frame_cnt  out  16  frames forwarded, wraps at 0xFFFF
- drop_cnt  out  16  frames dropped, wraps at 0xFFFF

## Operation
- Input pointer word: [11:0] is the length in bytes; [15] is the bad-frame flag (CRC/alignment error); [14:12] are ignored.
- Output pointer word: [15:14] source port; [13:12] are 0; [11:0] is the length.
- Every FIFO read has 1-cycle latency: dout is valid the cycle after rd.
- FSM states: IDLE, PTR_RD, PTR_LAT, CHECK, DATA, TAIL, PTR_WR.
  - IDLE: if any ptr_fifo_empty bit is 0, select a port by round-robin and go to PTR_RD. Search starts at last_grant+1 mod 4. last_grant resets to 3, so port 0 has first priority.
  - PTR_RD: ptr_fifo_rd[sel]=1 for exactly 1 cycle; last_grant<=sel.
  - PTR_LAT: latch ptr_fifo_din[sel] into len/bad registers.
  - CHECK, drop case (bad=1, len=0 or len>MAX_LEN):
    - drop_cnt++.
    - If len=0, go to IDLE; otherwise go to DATA in drop mode.
    - Drop mode performs all len data reads, with out_data_wr held 0.
  - CHECK, forward case: go to DATA only when out_ptr_full=0 and out_data_free>=len. Otherwise hold in CHECK indefinitely. No other port is served while holding (head-of-line by design).
  - DATA: data_fifo_rd[sel]=1 for exactly len consecutive cycles, controlled by a 12-bit down-counter. Go to TAIL after the last read.
  - TAIL: 1 cycle, allowing the final byte to be written.
  - PTR_WR: out_ptr_wr=1 for 1 cycle, unless in drop mode. frame_cnt++ on a forwarded frame. Return to IDLE.
- Data path: out_data_wr is data_fifo_rd[sel] delayed 1 cycle and suppressed in drop mode. out_data is data_fifo_din[8*sel+:8], registered.
- At most one bit of ptr_fifo_rd and at most one bit of data_fifo_rd is high in any cycle; their union is never high in the same cycle.
- Compare width: len and out_data_free are unsigned 12-bit values; the comparison is >=.

## Timing
- Reset value of every output is 0: strobes, out_data, out_ptr, frame_cnt, drop_cnt. FSM resets to IDLE.
- Forwarded frame, with T = the cycle in PTR_RD:
  - Pointer latched at T+1; CHECK at T+2.
  - Data reads run from T+3 to T+2+len.
  - out_data_wr runs from T+4 to T+3+len.
  - out_ptr_wr at T+4+len.
  - IDLE at T+5+len, when the next grant may be decided.
- Per-frame overhead is 6 cycles plus len if there is no stall.
- out_ptr_wr is always strictly after the last out_data_wr of its frame.
- Simultaneous requests: exactly one grant per IDLE pass; the other ports wait for later rounds.
- A port whose empty bit rises while another port is being served is considered at the next IDLE.
- Reset mid-frame aborts immediately and clears all state. The partial frame remains in the source FIFOs, so the system must reset those FIFOs together with this block.

## Test plan
- Single frame: port 2, ptr 0x0040, bytes 0x00..0x3F, out_data_free=4095. Required: 64 out_data_wr with identical bytes; out_ptr=0x8040 one cycle after the last byte; frame_cnt=1.
- Round-robin: ports 0,1,3 each hold one 64-byte frame, all available at once. Required: service order 0,1,3. Next, give port 0 and port 1 a new frame each with last_grant=3. Required: port 0 is served first.
- Drop: port 1 ptr 0x8080 (bad, 128 bytes) followed by ptr 0x0010. Required:
  - 128 data reads with no out_data_wr and no out_ptr_wr.
  - drop_cnt=1.
  - Second frame forwarded with out_ptr=0x4010.
- Illegal length: ptr 0x0000, then a separate frame with ptr 0x0600 (1536>MAX_LEN). Required:
  - First frame: no data reads.
  - Second frame: 1536 reads, not forwarded.
  - drop_cnt=2.
- Backpressure: 1000-byte frame with out_data_free=999. Required: FSM holds in CHECK with no data reads. When out_data_free is set to 1000, transfer starts 1 cycle later. Repeat with out_ptr_full=1. Required: same stall.
- Reset mid-frame: assert rst at byte 20 of a 64-byte frame. Required: next cycle, all outputs are 0, counters are 0 and FSM is IDLE.

Source files
------------

// File: rtl/mac_rx_arbiter.sv
// mac_rx_arbiter
// Drains four receive MAC ports into one shared ingress FIFO pair, one whole
// frame at a time, using a round-robin choice between ports. Each forwarded
// frame is tagged with its source port. Frames flagged bad, of length zero, or
// longer than MAX_LEN are read out of the source data FIFO and discarded.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ptr_fifo_*      per-port frame-pointer FIFOs (empty in, rd out, 4x16 dout in)
//   data_fifo_*     per-port byte data FIFOs (rd out, 4x8 dout in)
//   out_data(_wr)   byte and write strobe toward the ingress data FIFO
//   out_ptr(_wr)    pointer word and write strobe toward the ingress pointer FIFO
//   out_ptr_full    ingress pointer FIFO full
//   out_data_free   free byte locations in the ingress data FIFO
//   frame_cnt       frames forwarded (wrapping)
//   drop_cnt        frames dropped (wrapping)
//   fsm_state       current controller state, for observation
//
// Strobe semantics: every *_rd and *_wr output is a single-cycle transfer
// strobe; a transfer happens in every cycle the strobe is high. Source FIFO
// read data is presented on *_din the cycle after the read strobe. Upstream
// readiness is expressed by ptr_fifo_empty=0; downstream readiness by
// out_ptr_full=0 together with out_data_free covering the whole frame.
module mac_rx_arbiter #(
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ptr_fifo_empty,
  output logic [3:0]  ptr_fifo_rd,
  input  logic [63:0] ptr_fifo_din,
  output logic [3:0]  data_fifo_rd,
  input  logic [31:0] data_fifo_din,
  output logic [7:0]  out_data,
  output logic        out_data_wr,
  output logic [15:0] out_ptr,
  output logic        out_ptr_wr,
  input  logic        out_ptr_full,
  input  logic [11:0] out_data_free,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic [2:0]  fsm_state
);

  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PTR_RD  = 3'd1,
    PTR_LAT = 3'd2,
    CHECK   = 3'd3,
    DATA    = 3'd4,
    TAIL    = 3'd5,
    PTR_WR  = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  sel;
  logic [1:0]  last_grant;
  logic [1:0]  rr_pick;
  logic [1:0]  rr_idx;
  logic        rr_hit;
  logic [11:0] len;
  logic [11:0] cnt;
  logic        bad;
  logic        drop;
  logic        wr_q;
  logic        drop_now;
  logic        room_ok;

  assign fsm_state = state;

  // Round-robin search: offsets 4 down to 1 from last_grant, so the last
  // assignment (smallest offset, i.e. last_grant+1) wins. Offset 4 wraps to
  // last_grant itself, which therefore has the lowest priority.
  always_comb begin
    rr_pick = last_grant;
    rr_hit  = 1'b0;
    rr_idx  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      rr_idx = last_grant + 2'(k);
      if (!ptr_fifo_empty[rr_idx]) begin
        rr_pick = rr_idx;
        rr_hit  = 1'b1;
      end
    end
  end

  assign drop_now = bad || (len == 12'd0) || (len > MAX_LEN_W);
  assign room_ok  = !out_ptr_full && (out_data_free >= len);

  // Source data FIFO output is already registered; the byte is passed through
  // in the cycle its write strobe is up and held at 0 otherwise.
  assign out_data    = wr_q ? data_fifo_din[{sel, 3'b000} +: 8] : 8'h00;
  assign out_data_wr = wr_q;

  always_comb begin
    state_nxt    = state;
    ptr_fifo_rd  = 4'b0000;
    data_fifo_rd = 4'b0000;
    out_ptr_wr   = 1'b0;
    case (state)
      IDLE:    if (rr_hit) state_nxt = PTR_RD;
      PTR_RD: begin
        ptr_fifo_rd[sel] = 1'b1;
        state_nxt        = PTR_LAT;
      end
      PTR_LAT: state_nxt = CHECK;
      CHECK: begin
        // A forward frame waits here for room; no other port is served meanwhile.
        if (drop_now)     state_nxt = (len == 12'd0) ? IDLE : DATA;
        else if (room_ok) state_nxt = DATA;
      end
      DATA: begin
        data_fifo_rd[sel] = 1'b1;
        if (cnt == 12'd1) state_nxt = TAIL;
      end
      TAIL:    state_nxt = PTR_WR;
      PTR_WR: begin
        out_ptr_wr = !drop;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 2'd0;
      last_grant <= 2'd3;
      len        <= 12'd0;
      bad        <= 1'b0;
      cnt        <= 12'd0;
      drop       <= 1'b0;
      wr_q       <= 1'b0;
      out_ptr    <= 16'h0000;
      frame_cnt  <= 16'h0000;
      drop_cnt   <= 16'h0000;
    end else begin
      state <= state_nxt;
      wr_q  <= (state == DATA) && !drop;
      case (state)
        IDLE:    if (rr_hit) sel <= rr_pick;
        PTR_RD:  last_grant <= sel;
        PTR_LAT: begin
          len <= ptr_fifo_din[{sel, 4'h0} +: 12];
          bad <= ptr_fifo_din[{sel, 4'hF}];
        end
        CHECK: begin
          if (drop_now) begin
            drop     <= 1'b1;
            cnt      <= len;
            drop_cnt <= drop_cnt + 16'd1;
          end else if (room_ok) begin
            drop    <= 1'b0;
            cnt     <= len;
            out_ptr <= {sel, 2'b00, len};
          end
        end
        DATA:    cnt <= cnt - 12'd1;
        PTR_WR:  if (!drop) frame_cnt <= frame_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx_arbiter.sv
// Bench for mac_rx_arbiter: behavioural source FIFOs, scoreboard queues for
// the expected ingress bytes and pointer words, and directed scenarios.
module tb_mac_rx_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  ptr_fifo_empty = 4'hF;
  logic [3:0]  ptr_fifo_rd;
  logic [63:0] ptr_fifo_din;
  logic [3:0]  data_fifo_rd;
  logic [31:0] data_fifo_din;
  logic [7:0]  out_data;
  logic        out_data_wr;
  logic [15:0] out_ptr;
  logic        out_ptr_wr;
  logic        out_ptr_full = 1'b0;
  logic [11:0] out_data_free = 12'd4095;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic [2:0]  fsm_state;

  mac_rx_arbiter #(.MAX_LEN(1518)) dut (
    .clk(clk), .rst(rst),
    .ptr_fifo_empty(ptr_fifo_empty), .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_din(ptr_fifo_din),
    .data_fifo_rd(data_fifo_rd), .data_fifo_din(data_fifo_din),
    .out_data(out_data), .out_data_wr(out_data_wr),
    .out_ptr(out_ptr), .out_ptr_wr(out_ptr_wr),
    .out_ptr_full(out_ptr_full), .out_data_free(out_data_free),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- source FIFO models ----------------
  logic [15:0] pq[4][$];
  logic [7:0]  dq[4][$];
  logic [15:0] ptr_dout[4] = '{default: 16'h0};
  logic [7:0]  data_dout[4] = '{default: 8'h0};
  int data_reads[4] = '{default: 0};
  int underflow_cnt = 0;
  int cyc = 0;

  assign ptr_fifo_din  = {ptr_dout[3], ptr_dout[2], ptr_dout[1], ptr_dout[0]};
  assign data_fifo_din = {data_dout[3], data_dout[2], data_dout[1], data_dout[0]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (!rst && ptr_fifo_rd[i]) begin
        if (pq[i].size() != 0) ptr_dout[i] <= pq[i].pop_front();
        else underflow_cnt <= underflow_cnt + 1;
      end
      if (!rst && data_fifo_rd[i]) begin
        data_reads[i] <= data_reads[i] + 1;
        if (dq[i].size() != 0) data_dout[i] <= dq[i].pop_front();
        else underflow_cnt <= underflow_cnt + 1;
      end
      ptr_fifo_empty[i] <= (pq[i].size() == 0);
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [15:0] exp_ptr_q[$];
  int rd_cyc_q[$];
  int bytes_seen = 0;
  int ptr_wr_count = 0;
  int ptr_rd_cyc = 0, first_wr_cyc = -1, last_wr_cyc = 0, ptr_wr_cyc = 0;
  int excl_viol = 0;
  logic [15:0] mon_e;

  always @(negedge clk) begin
    if (rst) begin
      bytes_seen = 0;
    end else begin
      if (((|ptr_fifo_rd) && (|data_fifo_rd)) || $countones(ptr_fifo_rd) > 1 ||
          $countones(data_fifo_rd) > 1)
        excl_viol++;
      if (|ptr_fifo_rd) begin
        ptr_rd_cyc = cyc;
        rd_cyc_q.push_back(cyc);
      end
      if (out_data_wr) begin
        if (exp_q.size() == 0) check("unexpected_data_wr", 32'(out_data), -1);
        else begin
          mon_e = 16'(exp_q.pop_front());
          check("data_byte", 32'(out_data), 32'(mon_e));
        end
        bytes_seen++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
      end
      if (out_ptr_wr) begin
        if (exp_ptr_q.size() == 0) check("unexpected_ptr_wr", 32'(out_ptr), -1);
        else begin
          mon_e = exp_ptr_q.pop_front();
          check("out_ptr", 32'(out_ptr), 32'(mon_e));
          check("bytes_before_ptr", bytes_seen, 32'(mon_e[11:0]));
        end
        bytes_seen = 0;
        ptr_wr_count++;
        ptr_wr_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int port, input logic [15:0] ptr, input int nbytes,
                            input logic [7:0] base, input bit fwd, input logic [15:0] exp_ptr);
    logic [7:0] b;
    for (int k = 0; k < nbytes; k++) begin
      b = base + 8'(k);
      dq[port].push_back(b);
      if (fwd) exp_q.push_back(b);
    end
    pq[port].push_back(ptr);
    if (fwd) exp_ptr_q.push_back(exp_ptr);
  endtask

  function automatic bit drained();
    bit d;
    d = (exp_ptr_q.size() == 0) && (exp_q.size() == 0) && (fsm_state == 3'd0);
    for (int i = 0; i < 4; i++)
      if (pq[i].size() != 0 || dq[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (n < budget && !drained()) begin
      @(negedge clk);
      n++;
    end
    check({"done_", name}, int'(drained()), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ptr_fifo_rd"}, 32'(ptr_fifo_rd), 0);
    check({tag, "_data_fifo_rd"}, 32'(data_fifo_rd), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_out_data_wr"}, 32'(out_data_wr), 0);
    check({tag, "_out_ptr"}, 32'(out_ptr), 0);
    check({tag, "_out_ptr_wr"}, 32'(out_ptr_wr), 0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
    check({tag, "_fsm_state"}, 32'(fsm_state), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  int r0, w0, n;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single frame: port 2, 64 bytes 0x00..0x3F
    push_frame(2, 16'h0040, 64, 8'h00, 1'b1, 16'h8040);
    first_wr_cyc = -1;
    wait_done("single", 400);
    check("single_frame_cnt", 32'(frame_cnt), 1);
    check("single_drop_cnt", 32'(drop_cnt), 0);
    check("single_reads", data_reads[2], 64);
    check("single_first_wr_lat", first_wr_cyc - ptr_rd_cyc, 4);
    check("single_ptr_wr_lat", ptr_wr_cyc - ptr_rd_cyc, 68);
    check("single_ptr_after_last_byte", ptr_wr_cyc - last_wr_cyc, 1);

    // Round-robin from a fresh reset (last_grant = 3)
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    rd_cyc_q.delete();
    push_frame(0, 16'h0040, 64, 8'h10, 1'b1, 16'h0040);
    push_frame(1, 16'h0040, 64, 8'h50, 1'b1, 16'h4040);
    push_frame(3, 16'h0040, 64, 8'h90, 1'b1, 16'hC040);
    wait_done("rr3", 1000);
    check("rr_frame_cnt", 32'(frame_cnt), 3);
    check("rr_grants", rd_cyc_q.size(), 3);
    if (rd_cyc_q.size() == 3) begin
      check("rr_gap_01", rd_cyc_q[1] - rd_cyc_q[0], 70);
      check("rr_gap_13", rd_cyc_q[2] - rd_cyc_q[1], 70);
    end
    // last_grant is now 3: port 0 must win over port 1
    push_frame(0, 16'h0020, 32, 8'hC0, 1'b1, 16'h0020);
    push_frame(1, 16'h0020, 32, 8'hE0, 1'b1, 16'h4020);
    wait_done("rr2", 600);
    check("rr2_frame_cnt", 32'(frame_cnt), 5);

    // Drop: bad 128-byte frame then a good 16-byte frame on port 1
    r0 = data_reads[1]; w0 = ptr_wr_count;
    push_frame(1, 16'h8080, 128, 8'h33, 1'b0, 16'h0);
    push_frame(1, 16'h0010, 16, 8'h70, 1'b1, 16'h4010);
    wait_done("drop", 800);
    check("drop_reads", data_reads[1] - r0, 144);
    check("drop_drop_cnt", 32'(drop_cnt), 1);
    check("drop_frame_cnt", 32'(frame_cnt), 6);
    check("drop_ptr_writes", ptr_wr_count - w0, 1);

    // Illegal length 0: no data reads
    r0 = data_reads[0]; w0 = ptr_wr_count;
    push_frame(0, 16'h0000, 0, 8'h00, 1'b0, 16'h0);
    wait_done("len0", 100);
    check("len0_reads", data_reads[0] - r0, 0);
    check("len0_drop_cnt", 32'(drop_cnt), 2);
    // Illegal length 1536: all bytes read, nothing forwarded
    push_frame(0, 16'h0600, 1536, 8'h05, 1'b0, 16'h0);
    wait_done("len1536", 2000);
    check("len1536_reads", data_reads[0] - r0, 1536);
    check("len1536_drop_cnt", 32'(drop_cnt), 3);
    check("len1536_frame_cnt", 32'(frame_cnt), 6);
    check("len1536_ptr_writes", ptr_wr_count - w0, 0);

    // Boundary: 1518 forwarded, 1519 dropped
    push_frame(3, 16'h05EE, 1518, 8'h11, 1'b1, 16'hC5EE);
    push_frame(3, 16'h05EF, 1519, 8'h22, 1'b0, 16'h0);
    wait_done("maxlen", 4000);
    check("maxlen_frame_cnt", 32'(frame_cnt), 7);
    check("maxlen_drop_cnt", 32'(drop_cnt), 4);

    // Backpressure on free space: 1000-byte frame, 999 free
    out_data_free = 12'd999;
    r0 = data_reads[2];
    push_frame(2, 16'h03E8, 1000, 8'h40, 1'b1, 16'h83E8);
    repeat (20) @(negedge clk);
    check("bp_free_state", 32'(fsm_state), 3);
    check("bp_free_no_reads", data_reads[2] - r0, 0);
    check("bp_free_rd_before", 32'(data_fifo_rd), 0);
    out_data_free = 12'd1000;
    @(negedge clk);
    check("bp_free_rd_after", 32'(data_fifo_rd), 32'h4);
    wait_done("bp_free", 1500);
    out_data_free = 12'd4095;

    // Backpressure on pointer FIFO full
    out_ptr_full = 1'b1;
    r0 = data_reads[3];
    push_frame(3, 16'h0064, 100, 8'h80, 1'b1, 16'hC064);
    repeat (20) @(negedge clk);
    check("bp_full_state", 32'(fsm_state), 3);
    check("bp_full_no_reads", data_reads[3] - r0, 0);
    out_ptr_full = 1'b0;
    @(negedge clk);
    check("bp_full_rd_after", 32'(data_fifo_rd), 32'h8);
    wait_done("bp_full", 400);
    check("bp_frame_cnt", 32'(frame_cnt), 9);

    // Reset mid-frame at about byte 20 of a 64-byte frame
    push_frame(0, 16'h0040, 64, 8'h00, 1'b1, 16'h0040);
    n = 0;
    while (n < 300 && bytes_seen < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_byte20", int'(bytes_seen >= 20), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_ptr_q.delete();
    for (int i = 0; i < 4; i++) begin
      pq[i].delete();
      dq[i].delete();
    end
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;

    // Recovery after reset
    push_frame(1, 16'h0008, 8, 8'hA0, 1'b1, 16'h4008);
    wait_done("recover", 200);
    check("recover_frame_cnt", 32'(frame_cnt), 1);

    check("strobe_exclusive_violations", excl_viol, 0);
    check("fifo_underflows", underflow_cnt, 0);
    check("exp_bytes_left", exp_q.size(), 0);
    check("exp_ptrs_left", exp_ptr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
